// File: rtl/ifid_pipe_reg.sv
// IF/ID pipeline register: captures PC+4 and the fetched instruction for decode,
// with hazard stall (hold), branch/jump flush (bubble) and saturating event counters.
module ifid_pipe_reg #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] NOP   = '0,
  parameter int               CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             Flush,
  input  logic             CounterClear,
  input  logic             ValidIn,
  input  logic [WIDTH-1:0] PCAddResultIn,
  input  logic [WIDTH-1:0] InstructionIn,
  output logic [WIDTH-1:0] PCAddResultOut,
  output logic [WIDTH-1:0] InstructionOut,
  output logic             ValidOut,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  logic [WIDTH-1:0] pc_p1;
  logic [WIDTH-1:0] instr_p1;
  logic             vld_p1;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // IF -> ID stage boundary
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_p1    <= '0;
      instr_p1 <= NOP;
      vld_p1   <= 1'b0;
    end else if (Flush) begin
      // Wrong-path slot: keep its PC+4 for debug, but present a bubble.
      pc_p1    <= PCAddResultIn;
      instr_p1 <= NOP;
      vld_p1   <= 1'b0;
    end else if (!Stall) begin
      pc_p1    <= PCAddResultIn;
      instr_p1 <= ValidIn ? InstructionIn : NOP;
      vld_p1   <= ValidIn;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (CounterClear) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (Stall && !Flush) stall_cnt <= sat_inc(stall_cnt);
      if (Flush)           flush_cnt <= sat_inc(flush_cnt);
    end
  end

  assign PCAddResultOut = pc_p1;
  assign InstructionOut = instr_p1;
  assign ValidOut       = vld_p1;
  assign StallCount     = stall_cnt;
  assign FlushCount     = flush_cnt;

endmodule
